// File: rtl/pwm_dimmer_defs.sv
// Shared encodings and sizing helpers for the PWM dimmer sequencer.
package pwm_dimmer_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FADE      = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_HOLD_HI   = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_HOLD_LO   = 3'd5
    } dim_state_e;

    localparam logic [1:0] MODE_MANUAL     = 2'b00;
    localparam logic [1:0] MODE_FADE       = 2'b01;
    localparam logic [1:0] MODE_BREATHE    = 2'b10;
    localparam logic [1:0] MODE_MANUAL_ALT = 2'b11;

    function automatic int duty_max(input int w);
        return (1 << w) - 1;
    endfunction

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Prescaler on period_end: emits step_tick once every STEP_PERIODS PWM periods.
module pwm_step_timer
    import pwm_dimmer_defs::*;
#(
    parameter int STEP_PERIODS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic period_end_i,
    output logic step_tick_o
);

    localparam int             CNT_W    = cnt_width(STEP_PERIODS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIODS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             terminal_s;

    // Next count and the combinational step strobe.
    always_comb begin
        terminal_s  = (cnt_q == CNT_LAST);
        step_tick_o = period_end_i && terminal_s;
        if (clr_i) begin
            cnt_d = '0;
        end else if (period_end_i) begin
            cnt_d = terminal_s ? '0 : (cnt_q + CNT_W'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_dimmer_ctrl.sv
// Duty-cycle sequencer for the LED PWM datapath: manual, fade-to-target and breathe modes,
// with every duty update aligned to a PWM period boundary.
module pwm_dimmer_ctrl
    import pwm_dimmer_defs::*;
#(
    parameter int DUTY_W       = 4,
    parameter int STEP_PERIODS = 8,
    parameter int HOLD_STEPS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DUTY_W-1:0] manual_duty,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              start,
    input  logic              stop,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(duty_max(DUTY_W));
    localparam int                HOLD_W    = cnt_width(HOLD_STEPS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? (HOLD_STEPS - 1) : 0);

    dim_state_e        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              timer_clr_s;
    logic              step_tick_s;
    logic              start_ok_s;
    logic [DUTY_W-1:0] duty_inc_s;
    logic [DUTY_W-1:0] duty_dec_s;
    logic [DUTY_W-1:0] fade_next_s;

    pwm_step_timer #(
        .STEP_PERIODS (STEP_PERIODS)
    ) u_step_timer (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (timer_clr_s),
        .period_end_i (period_end),
        .step_tick_o  (step_tick_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            hold_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and duty update; enable and stop override everything else.
    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        target_d    = target_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        timer_clr_s = 1'b0;
        start_ok_s  = start && !stop;
        duty_inc_s  = (duty_q == DUTY_MAX) ? duty_q : (duty_q + DUTY_W'(1));
        duty_dec_s  = (duty_q == '0) ? duty_q : (duty_q - DUTY_W'(1));
        if (duty_q < target_q) begin
            fade_next_s = duty_inc_s;
        end else if (duty_q > target_q) begin
            fade_next_s = duty_dec_s;
        end else begin
            fade_next_s = duty_q;
        end

        if (!enable) begin
            state_d     = ST_IDLE;
            duty_d      = '0;
            hold_d      = '0;
            timer_clr_s = 1'b1;
        end else if (stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_s && (mode == MODE_FADE)) begin
                        if (target_duty == duty_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = ST_FADE;
                            target_d    = target_duty;
                            timer_clr_s = 1'b1;
                        end
                    end else if (start_ok_s && (mode == MODE_BREATHE)) begin
                        state_d     = ST_RAMP_UP;
                        hold_d      = '0;
                        timer_clr_s = 1'b1;
                    end else if (period_end && ((mode == MODE_MANUAL) || (mode == MODE_MANUAL_ALT))) begin
                        duty_d = manual_duty;
                    end else begin
                        duty_d = duty_q;
                    end
                end
                ST_FADE: begin
                    if (step_tick_s) begin
                        duty_d = fade_next_s;
                        if (fade_next_s == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_FADE;
                        end
                    end else begin
                        duty_d = duty_q;
                    end
                end
                ST_RAMP_UP: begin
                    if (step_tick_s) begin
                        duty_d = duty_inc_s;
                        hold_d = '0;
                        if (duty_inc_s == DUTY_MAX) begin
                            state_d = (HOLD_STEPS == 0) ? ST_RAMP_DOWN : ST_HOLD_HI;
                        end else begin
                            state_d = ST_RAMP_UP;
                        end
                    end else begin
                        duty_d = duty_q;
                    end
                end
                ST_HOLD_HI: begin
                    if (step_tick_s) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_RAMP_DOWN;
                            hold_d  = '0;
                        end else begin
                            hold_d  = hold_q + HOLD_W'(1);
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (step_tick_s) begin
                        duty_d = duty_dec_s;
                        hold_d = '0;
                        if (duty_dec_s == '0) begin
                            state_d = (HOLD_STEPS == 0) ? ST_RAMP_UP : ST_HOLD_LO;
                        end else begin
                            state_d = ST_RAMP_DOWN;
                        end
                    end else begin
                        duty_d = duty_q;
                    end
                end
                ST_HOLD_LO: begin
                    if (step_tick_s) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_RAMP_UP;
                            hold_d  = '0;
                        end else begin
                            hold_d  = hold_q + HOLD_W'(1);
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Output decode, registered alongside the state so busy tracks state exactly.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pwm_dimmer_ctrl.sv
// Directed bench for pwm_dimmer_ctrl with STEP_PERIODS=2, HOLD_STEPS=1.
module tb_pwm_dimmer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] manual_duty;
    logic [3:0] target_duty;
    logic       start;
    logic       stop;
    logic       period_end;
    logic [3:0] duty_cycle;
    logic       busy;
    logic       done;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_dimmer_ctrl #(
        .DUTY_W       (4),
        .STEP_PERIODS (2),
        .HOLD_STEPS   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .manual_duty (manual_duty),
        .target_duty (target_duty),
        .start       (start),
        .stop        (stop),
        .period_end  (period_end),
        .duty_cycle  (duty_cycle),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    // All stimulus tasks begin and end on a falling edge.
    task automatic pe_pulse();
        @(negedge clk);
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; mode = 2'b00; manual_duty = 4'd0; target_duty = 4'd0;
        start = 1'b0; stop = 1'b0; period_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (duty_cycle !== 4'd0) begin bad++; $display("FAIL reset_duty: got %0d expected 0", duty_cycle); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", state); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", done); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_manual();
        mode = 2'b00; manual_duty = 4'd9;
        pe_pulse();
        total++; if (duty_cycle !== 4'd9) begin bad++; $display("FAIL manual_load: got %0d expected 9", duty_cycle); end
        manual_duty = 4'd3;
        repeat (3) @(negedge clk);
        total++; if (duty_cycle !== 4'd9) begin bad++; $display("FAIL manual_hold: got %0d expected 9", duty_cycle); end
        mode = 2'b11; manual_duty = 4'd0;
        pe_pulse();
        total++; if (duty_cycle !== 4'd0) begin bad++; $display("FAIL manual_mode11: got %0d expected 0", duty_cycle); end
    endtask

    task automatic test_fade_up();
        int n_done = 0;
        mode = 2'b01; target_duty = 4'd5;
        start_pulse();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL fade_up_state: got %0d expected 1", state); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fade_up_busy: got %0b expected 1", busy); end
        target_duty = 4'd9;
        for (int k = 1; k <= 10; k++) begin
            pe_pulse();
            if (done === 1'b1) n_done++;
            total++; if (duty_cycle !== 4'(k / 2)) begin bad++; $display("FAIL fade_up_step%0d: got %0d expected %0d", k, duty_cycle, k / 2); end
        end
        total++; if (n_done != 1) begin bad++; $display("FAIL fade_up_done_count: got %0d expected 1", n_done); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL fade_up_end_state: got %0d expected 0", state); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fade_up_end_busy: got %0b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fade_up_done_width: got %0b expected 0", done); end
    endtask

    task automatic test_fade_equal();
        mode = 2'b00; manual_duty = 4'd7;
        pe_pulse();
        total++; if (duty_cycle !== 4'd7) begin bad++; $display("FAIL eq_preload: got %0d expected 7", duty_cycle); end
        mode = 2'b01; target_duty = 4'd7;
        start_pulse();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL eq_done: got %0b expected 1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL eq_busy: got %0b expected 0", busy); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL eq_state: got %0d expected 0", state); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL eq_done_clear: got %0b expected 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL eq_busy_after: got %0b expected 0", busy); end
    endtask

    task automatic test_fade_down();
        int exp_d;
        mode = 2'b00; manual_duty = 4'd12;
        pe_pulse();
        total++; if (duty_cycle !== 4'd12) begin bad++; $display("FAIL down_preload: got %0d expected 12", duty_cycle); end
        mode = 2'b01; target_duty = 4'd3;
        start_pulse();
        for (int k = 1; k <= 20; k++) begin
            pe_pulse();
            exp_d = (k <= 18) ? (12 - k / 2) : 3;
            total++; if (duty_cycle !== 4'(exp_d)) begin bad++; $display("FAIL down_step%0d: got %0d expected %0d", k, duty_cycle, exp_d); end
            total++; if (done !== (k == 18)) begin bad++; $display("FAIL down_done%0d: got %0b expected %0b", k, done, (k == 18)); end
        end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL down_end_state: got %0d expected 0", state); end
    endtask

    task automatic test_breathe();
        bit saw_done = 1'b0;
        bit chk;
        int exp_d;
        int exp_s;
        mode = 2'b00; manual_duty = 4'd0;
        pe_pulse();
        mode = 2'b10;
        start_pulse();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL br_start_state: got %0d expected 2", state); end
        for (int k = 1; k <= 76; k++) begin
            pe_pulse();
            if (done === 1'b1) saw_done = 1'b1;
            if (k < 30) begin
                total++; if (duty_cycle !== 4'(k / 2)) begin bad++; $display("FAIL br_up%0d: got %0d expected %0d", k, duty_cycle, k / 2); end
            end
            chk = 1'b1; exp_d = 0; exp_s = 0;
            case (k)
                30: begin exp_d = 15; exp_s = 3; end
                32: begin exp_d = 15; exp_s = 4; end
                34: begin exp_d = 14; exp_s = 4; end
                62: begin exp_d = 0;  exp_s = 5; end
                64: begin exp_d = 0;  exp_s = 2; end
                66: begin exp_d = 1;  exp_s = 2; end
                76: begin exp_d = 6;  exp_s = 2; end
                default: chk = 1'b0;
            endcase
            if (chk) begin
                total++; if (duty_cycle !== 4'(exp_d)) begin bad++; $display("FAIL br_duty_pe%0d: got %0d expected %0d", k, duty_cycle, exp_d); end
                total++; if (state !== 3'(exp_s)) begin bad++; $display("FAIL br_state_pe%0d: got %0d expected %0d", k, state, exp_s); end
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL br_stop_state: got %0d expected 0", state); end
        total++; if (duty_cycle !== 4'd6) begin bad++; $display("FAIL br_stop_duty: got %0d expected 6", duty_cycle); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL br_stop_busy: got %0b expected 0", busy); end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL br_no_done: got %0b expected 0", saw_done); end
        pe_pulse();
        total++; if (duty_cycle !== 4'd6) begin bad++; $display("FAIL br_idle_keep: got %0d expected 6", duty_cycle); end
    endtask

    task automatic test_priority();
        mode = 2'b01; target_duty = 4'd10;
        start_pulse();
        pe_pulse();
        pe_pulse();
        total++; if (duty_cycle !== 4'd7) begin bad++; $display("FAIL pri_fade7: got %0d expected 7", duty_cycle); end
        pe_pulse();
        mode = 2'b10;
        start_pulse();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL pri_busy_start: got %0d expected 1", state); end
        pe_pulse();
        total++; if (duty_cycle !== 4'd8) begin bad++; $display("FAIL pri_no_clear: got %0d expected 8", duty_cycle); end
        mode = 2'b01;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL pri_stop_wins: got %0d expected 0", state); end
        total++; if (duty_cycle !== 4'd8) begin bad++; $display("FAIL pri_stop_duty: got %0d expected 8", duty_cycle); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL pri_stop_done: got %0b expected 0", done); end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pri_idle_stop_wins: got %0b expected 0", busy); end
        start_pulse();
        pe_pulse();
        pe_pulse();
        total++; if (duty_cycle !== 4'd9) begin bad++; $display("FAIL pri_fade9: got %0d expected 9", duty_cycle); end
        enable = 1'b0;
        @(negedge clk);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL pri_dis_state: got %0d expected 0", state); end
        total++; if (duty_cycle !== 4'd0) begin bad++; $display("FAIL pri_dis_duty: got %0d expected 0", duty_cycle); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pri_dis_busy: got %0b expected 0", busy); end
        mode = 2'b10;
        start_pulse();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL pri_dis_start: got %0d expected 0", state); end
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        mode = 2'b10;
        start_pulse();
        repeat (6) pe_pulse();
        total++; if (duty_cycle !== 4'd3) begin bad++; $display("FAIL rst_pre_duty: got %0d expected 3", duty_cycle); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (duty_cycle !== 4'd0) begin bad++; $display("FAIL rst_async_duty: got %0d expected 0", duty_cycle); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_async_state: got %0d expected 0", state); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %0b expected 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) pe_pulse();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_no_resume_state: got %0d expected 0", state); end
        total++; if (duty_cycle !== 4'd0) begin bad++; $display("FAIL rst_no_resume_duty: got %0d expected 0", duty_cycle); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_fade_up();
        test_fade_equal();
        test_fade_down();
        test_breathe();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
